// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: drives a shared single-multiplier FIR MAC kernel.
// Takes one sample per handshake, issues NUM_TAPS products, returns the result.
//
// Ports
//   CLK, Reset           rising-edge clock, synchronous active-high reset
//   ap_start/ap_idle/    block control: start (sampled when idle), idle level,
//   ap_done/data_length  one-cycle done pulse, block length latched on start
//   ss_t*                input sample stream (slave)
//   sm_t*                filtered output stream (master)
//   tap_A/tap_Do         tap RAM read port, one cycle of read latency
//   k_en/k_first/k_x/    kernel operands and control for the current term
//   k_tap/k_y            plus the registered kernel accumulator
module fir_mac_sequencer #(
    parameter int NUM_TAPS = 11,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              ap_start,
    input  logic [31:0]       data_length,
    output logic              ap_idle,
    output logic              ap_done,
    input  logic              ss_tvalid,
    input  logic [DATA_W-1:0] ss_tdata,
    output logic              ss_tready,
    output logic              sm_tvalid,
    output logic [DATA_W-1:0] sm_tdata,
    input  logic              sm_tready,
    output logic [ADDR_W-1:0] tap_A,
    input  logic [DATA_W-1:0] tap_Do,
    output logic              k_en,
    output logic              k_first,
    output logic [DATA_W-1:0] k_x,
    output logic [DATA_W-1:0] k_tap,
    input  logic [DATA_W-1:0] k_y
);

    localparam int CNT_W = $clog2(NUM_TAPS + 1);
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(NUM_TAPS);
    localparam logic [CNT_W-1:0] ONE_TERM  = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IN,
        MAC,
        CAPTURE,
        OUT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;

    logic [31:0]       len_q;
    logic [31:0]       count_q;
    logic [31:0]       count_nx;
    logic [CNT_W-1:0]  term_q;
    logic [DATA_W-1:0] shift_q [NUM_TAPS];
    logic [DATA_W-1:0] sm_data_q;
    logic              sm_valid_q;
    logic              last_term;

    assign count_nx  = count_q + 32'd1;
    assign last_term = (term_q == LAST_TERM);
    assign sm_tdata  = sm_data_q;
    assign sm_tvalid = sm_valid_q;

    // State register
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (ap_start) begin
                    state_nx = (data_length == 32'd0) ? DONE : WAIT_IN;
                end
            end
            WAIT_IN: begin
                if (ss_tvalid) begin
                    state_nx = MAC;
                end
            end
            MAC: begin
                if (last_term) begin
                    state_nx = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nx = OUT;
            end
            OUT: begin
                if (sm_tready) begin
                    state_nx = (count_nx == len_q) ? DONE : WAIT_IN;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs decoded from state and term counter.
    // Term j addresses h[j]; the RAM answers a cycle later, so term j
    // multiplies h[j-1] by s[j-1] and no product is issued on term 0.
    always_comb begin
        ap_idle   = 1'b0;
        ap_done   = 1'b0;
        ss_tready = 1'b0;
        tap_A     = '0;
        k_en      = 1'b0;
        k_first   = 1'b0;
        k_x       = '0;
        k_tap     = '0;
        unique case (state)
            IDLE: begin
                ap_idle = 1'b1;
            end
            WAIT_IN: begin
                ss_tready = 1'b1;
            end
            MAC: begin
                if (!last_term) begin
                    tap_A = ADDR_W'(term_q);
                end
                if (term_q != '0) begin
                    k_en    = 1'b1;
                    k_first = (term_q == ONE_TERM);
                    k_tap   = tap_Do;
                    for (int i = 0; i < NUM_TAPS; i++) begin
                        if (term_q == CNT_W'(i + 1)) begin
                            k_x = shift_q[i];
                        end
                    end
                end
            end
            DONE: begin
                ap_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath: block length, sample count, term counter, history, result
    always_ff @(posedge CLK) begin
        if (Reset) begin
            len_q      <= '0;
            count_q    <= '0;
            term_q     <= '0;
            sm_data_q  <= '0;
            sm_valid_q <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                shift_q[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (ap_start) begin
                        len_q   <= data_length;
                        count_q <= '0;
                        for (int i = 0; i < NUM_TAPS; i++) begin
                            shift_q[i] <= '0;
                        end
                    end
                end
                WAIT_IN: begin
                    if (ss_tvalid) begin
                        for (int i = NUM_TAPS - 1; i > 0; i--) begin
                            shift_q[i] <= shift_q[i-1];
                        end
                        shift_q[0] <= ss_tdata;
                        term_q     <= '0;
                    end
                end
                MAC: begin
                    if (!last_term) begin
                        term_q <= term_q + ONE_TERM;
                    end
                end
                CAPTURE: begin
                    // k_y now holds the sum of the last term issued
                    sm_data_q  <= k_y;
                    sm_valid_q <= 1'b1;
                end
                OUT: begin
                    if (sm_tready) begin
                        sm_valid_q <= 1'b0;
                        count_q    <= count_nx;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed bench for fir_mac_sequencer.
// Models tap RAM and MAC kernel; a convolution model predicts every output.
module tb_fir_mac_sequencer;

    localparam int NT = 11;
    localparam int DW = 32;
    localparam int AW = 4;

    logic          CLK = 1'b0;
    logic          Reset = 1'b1;
    logic          ap_start = 1'b0;
    logic [31:0]   data_length = '0;
    logic          ap_idle;
    logic          ap_done;
    logic          ss_tvalid = 1'b0;
    logic [DW-1:0] ss_tdata = '0;
    logic          ss_tready;
    logic          sm_tvalid;
    logic [DW-1:0] sm_tdata;
    logic          sm_tready = 1'b1;
    logic [AW-1:0] tap_A;
    logic [DW-1:0] tap_Do = '0;
    logic          k_en;
    logic          k_first;
    logic [DW-1:0] k_x;
    logic [DW-1:0] k_tap;
    logic [DW-1:0] k_y;

    fir_mac_sequencer #(
        .NUM_TAPS(NT),
        .DATA_W  (DW),
        .ADDR_W  (AW)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .ap_start   (ap_start),
        .data_length(data_length),
        .ap_idle    (ap_idle),
        .ap_done    (ap_done),
        .ss_tvalid  (ss_tvalid),
        .ss_tdata   (ss_tdata),
        .ss_tready  (ss_tready),
        .sm_tvalid  (sm_tvalid),
        .sm_tdata   (sm_tdata),
        .sm_tready  (sm_tready),
        .tap_A      (tap_A),
        .tap_Do     (tap_Do),
        .k_en       (k_en),
        .k_first    (k_first),
        .k_x        (k_x),
        .k_tap      (k_tap),
        .k_y        (k_y)
    );

    always #5 CLK = ~CLK;

    int chk_cnt = 0;
    int pass_cnt = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endfunction

    // Tap RAM with one cycle of read latency
    logic [DW-1:0] taps [16];
    always @(posedge CLK) tap_Do <= taps[tap_A];

    // MAC kernel: registered accumulator, modulo 2^DW
    logic [DW-1:0] acc = '0;
    always @(posedge CLK) begin
        if (k_en) acc <= k_first ? k_x * k_tap : acc + k_x * k_tap;
    end
    assign k_y = acc;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Output sink with programmable backpressure
    int bp_cycles = 0;
    int hold_cnt = 0;
    always @(posedge CLK) begin
        #1;
        if (sm_tvalid && !sm_tready) begin
            if (hold_cnt >= bp_cycles) sm_tready = 1'b1;
            else hold_cnt++;
        end else if (!sm_tvalid) begin
            sm_tready = (bp_cycles == 0);
            hold_cnt = 0;
        end
    end

    // Behavioural model and per-cycle compare
    logic [DW-1:0] hist [NT];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] obs_q [$];
    logic [DW-1:0] y;
    logic [DW-1:0] prev_d = '0;
    logic          prev_v = 1'b0;
    logic          prev_r = 1'b0;
    int hs_edge = 0;
    int lat_last = 0;
    int last_out_edge = -1;
    int done_cnt = 0;
    int done_cyc = -1;
    int ken_cnt = 0;
    int kf_cnt = 0;
    int ken_first = -1;
    int ken_last = -1;
    int kf_cyc = -1;
    int hold_n = 0;

    always @(negedge CLK) begin
        if (Reset) begin
            exp_q.delete();
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (ap_idle && ap_start) begin
                for (int k = 0; k < NT; k++) hist[k] = '0;
            end
            if (ss_tvalid && ss_tready) begin
                for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = ss_tdata;
                y = '0;
                for (int k = 0; k < NT; k++) y = y + taps[k] * hist[k];
                exp_q.push_back(y);
                hs_edge = cyc + 1;
                ken_cnt = 0;
                kf_cnt = 0;
                ken_first = -1;
                kf_cyc = -1;
            end
            if (k_en) begin
                if (ken_first < 0) ken_first = cyc;
                ken_last = cyc;
                ken_cnt++;
            end
            if (k_first) begin
                kf_cnt++;
                kf_cyc = cyc;
            end
            if (sm_tvalid) chk("no_input_while_pending", {63'd0, ss_tready}, 64'd0);
            if (sm_tvalid && !prev_v) begin
                lat_last = cyc - hs_edge;
                chk("latency", 64'(lat_last), 64'(NT + 2));
            end
            if (prev_v && !prev_r) begin
                hold_n++;
                chk("hold_valid", {63'd0, sm_tvalid}, 64'd1);
                chk("hold_data", 64'(sm_tdata), 64'(prev_d));
            end
            if (sm_tvalid && sm_tready) begin
                if (exp_q.size() == 0) chk("spurious_output", 64'(sm_tdata), 64'hDEAD);
                else chk("y_model", 64'(sm_tdata), 64'(exp_q.pop_front()));
                obs_q.push_back(sm_tdata);
                last_out_edge = cyc + 1;
            end
            if (ap_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_v = sm_tvalid;
            prev_r = sm_tready;
            prev_d = sm_tdata;
        end
    end

    task automatic start(input logic [31:0] len, output int e0);
        @(posedge CLK); #1;
        ap_start = 1'b1;
        data_length = len;
        @(posedge CLK); #1;
        e0 = cyc;
        ap_start = 1'b0;
    endtask

    task automatic send(input logic [31:0] x);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        ss_tvalid = 1'b1;
        ss_tdata = x;
        while (!got && n < 400) begin
            @(negedge CLK);
            got = ss_tready;
            n++;
        end
        chk("input_accepted", {63'd0, got}, 64'd1);
        @(posedge CLK); #1;
        ss_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        while (!ok && n < 1000) begin
            @(negedge CLK);
            ok = ap_idle;
            n++;
        end
        chk("idle_reached", {63'd0, ok}, 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctl"}, {60'd0, ap_idle, ap_done, ss_tready, sm_tvalid}, 64'b1000);
        chk({tag, "_sm_tdata"}, 64'(sm_tdata), 64'd0);
        chk({tag, "_tap_A"}, 64'(tap_A), 64'd0);
        chk({tag, "_k_ctl"}, {62'd0, k_en, k_first}, 64'd0);
        chk({tag, "_k_x"}, 64'(k_x), 64'd0);
        chk({tag, "_k_tap"}, 64'(k_tap), 64'd0);
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 16; k++) taps[k] = (k < NT) ? DW'(k + 1) : '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e0;
        int d0;
        int h0;
        for (int k = 0; k < 16; k++) taps[k] = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_reset_vals("reset");
        @(posedge CLK); #1;
        Reset = 1'b0;

        // Basic filter: h = 1..11, x = 1,2,3 -> 1, 4, 10
        set_ramp();
        obs_q.delete();
        d0 = done_cnt;
        start(32'd3, e0);
        send(32'd1);
        send(32'd2);
        send(32'd3);
        wait_idle();
        chk("basic_count", 64'(obs_q.size()), 64'd3);
        chk("basic_y0", 64'(obs_q[0]), 64'd1);
        chk("basic_y1", 64'(obs_q[1]), 64'd4);
        chk("basic_y2", 64'(obs_q[2]), 64'd10);
        chk("basic_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("basic_done_after_out", 64'(done_cyc), 64'(last_out_edge));

        // Latency and kernel protocol: h = all 1, single sample 5
        for (int k = 0; k < 16; k++) taps[k] = (k < NT) ? 32'd1 : 32'd0;
        obs_q.delete();
        start(32'd1, e0);
        send(32'd5);
        wait_idle();
        chk("lat_y", 64'(obs_q[0]), 64'd5);
        chk("lat_edges", 64'(lat_last), 64'd13);
        chk("k_en_count", 64'(ken_cnt), 64'd11);
        chk("k_en_span", 64'(ken_last - ken_first), 64'd10);
        chk("k_first_count", 64'(kf_cnt), 64'd1);
        chk("k_first_on_first", 64'(kf_cyc), 64'(ken_first));

        // Backpressure: 7 stalled cycles per output, x = 4,6 -> 4, 14
        set_ramp();
        obs_q.delete();
        bp_cycles = 7;
        h0 = hold_n;
        start(32'd2, e0);
        send(32'd4);
        send(32'd6);
        wait_idle();
        bp_cycles = 0;
        chk("bp_y0", 64'(obs_q[0]), 64'd4);
        chk("bp_y1", 64'(obs_q[1]), 64'd14);
        chk("bp_hold_cycles", 64'(hold_n - h0), 64'd14);

        // Empty block
        obs_q.delete();
        d0 = done_cnt;
        start(32'd0, e0);
        @(negedge CLK);
        chk("len0_done", {63'd0, ap_done}, 64'd1);
        chk("len0_busy", {61'd0, ap_idle, ss_tready, sm_tvalid}, 64'd0);
        @(negedge CLK);
        chk("len0_back_idle", {62'd0, ap_idle, ap_done}, 64'b10);
        chk("len0_done_edge", 64'(done_cyc), 64'(e0));
        chk("len0_done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("len0_no_output", 64'(obs_q.size()), 64'd0);

        // Wrap: h0 = 2, x = 0xFFFFFFFF -> 0xFFFFFFFE
        for (int k = 0; k < 16; k++) taps[k] = '0;
        taps[0] = 32'd2;
        obs_q.delete();
        start(32'd1, e0);
        send(32'hFFFF_FFFF);
        wait_idle();
        chk("wrap_y", 64'(obs_q[0]), 64'hFFFF_FFFE);

        // Reset during MAC cycle 5, then restart
        set_ramp();
        obs_q.delete();
        start(32'd2, e0);
        send(32'd9);
        repeat (5) @(posedge CLK);
        #1;
        Reset = 1'b1;
        @(negedge CLK);
        chk("pre_reset_in_mac", {63'd0, k_en}, 64'd1);
        @(posedge CLK); #1;
        Reset = 1'b0;
        @(negedge CLK);
        check_reset_vals("abort");
        start(32'd1, e0);
        send(32'd7);
        wait_idle();
        chk("restart_count", 64'(obs_q.size()), 64'd1);
        chk("restart_y", 64'(obs_q[0]), 64'd7);
        chk("no_missing_outputs", 64'(exp_q.size()), 64'd0);

        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
